scroll_ctrl: RTL and testbench

SCROLL_CTRL -- requirements
Module: scroll_ctrl

---
 rtl/scroll_ctrl.sv | 162 ++++++++++++++++
 tb/tb_scroll_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scroll_ctrl.sv
// Side-scroller game controller: IDLE/RUN/PAUSE/OVER sequencing plus the
// per-frame scroll, speed ramp, coin collection and score bookkeeping.
module scroll_ctrl #(
  parameter int OFFSET_MAX  = 4095,
  parameter int SPEED_INIT  = 2,
  parameter int SPEED_MAX   = 6,
  parameter int RAMP_FRAMES = 600,
  parameter int COIN_POINTS = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        start,
  input  logic        pause,
  input  logic        dead,
  input  logic [3:0]  coin_hit,
  output logic        playing,
  output logic [11:0] scroll_offset,
  output logic [2:0]  speed,
  output logic [3:0]  coin_taken,
  output logic [15:0] score,
  output logic [7:0]  lap,
  output logic [1:0]  state
);

  localparam int RAMP_W = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                playing_q, playing_d;
  logic [11:0]         offset_q, offset_d;
  logic [2:0]          speed_q, speed_d;
  logic [3:0]          taken_q, taken_d;
  logic [15:0]         score_q, score_d;
  logic [7:0]          lap_q, lap_d;
  logic [RAMP_W-1:0]   ramp_q, ramp_d;
  logic                fc0_q, fc1_q;

  logic                frame_tick;
  logic [12:0]         sum;
  logic                wrap;
  logic [3:0]          new_coins;
  logic [2:0]          n_new;
  logic [18:0]         score_sum;

  // frame_clk is asynchronous; the first flop samples it, the second gives the edge.
  assign frame_tick = fc0_q & ~fc1_q;

  always_comb begin
    state_d   = state_q;
    offset_d  = offset_q;
    speed_d   = speed_q;
    taken_d   = taken_q;
    score_d   = score_q;
    lap_d     = lap_q;
    ramp_d    = ramp_q;
    sum       = {1'b0, offset_q} + {10'd0, speed_q};
    wrap      = 1'b0;
    new_coins = 4'd0;
    n_new     = 3'd0;
    score_sum = 19'd0;

    case (state_q)
      S_IDLE: begin
        offset_d = 12'd0;
        if (start) begin
          state_d = S_RUN;
          speed_d = 3'(SPEED_INIT);
          score_d = 16'd0;
          lap_d   = 8'd0;
          taken_d = 4'd0;
          ramp_d  = '0;
        end
      end

      S_RUN: begin
        if (frame_tick) begin
          if (sum > 13'(OFFSET_MAX)) begin
            wrap     = 1'b1;
            offset_d = 12'(sum - 13'(OFFSET_MAX + 1));
            lap_d    = lap_q + 8'd1;
            taken_d  = 4'd0;
          end else begin
            offset_d = sum[11:0];
          end
          if (ramp_q == RAMP_W'(RAMP_FRAMES - 1)) begin
            ramp_d  = '0;
            speed_d = (speed_q >= 3'(SPEED_MAX)) ? 3'(SPEED_MAX) : speed_q + 3'd1;
          end else begin
            ramp_d = ramp_q + 1'b1;
          end
        end
        // A wrap resets the coin row, so touches in that same cycle are dropped.
        if (!wrap) begin
          new_coins = coin_hit & ~taken_q;
          taken_d   = taken_q | new_coins;
        end
        for (int i = 0; i < 4; i++) begin
          n_new = n_new + {2'd0, new_coins[i]};
        end
        score_sum = {3'd0, score_q} + 19'(COIN_POINTS) * {16'd0, n_new}
                  + {18'd0, frame_tick};
        score_d   = (score_sum > 19'd65535) ? 16'hFFFF : score_sum[15:0];

        if (dead)       state_d = S_OVER;
        else if (pause) state_d = S_PAUSE;
      end

      S_PAUSE: begin
        if (dead)       state_d = S_OVER;
        else if (pause) state_d = S_RUN;
      end

      default: begin
        if (start) state_d = S_IDLE;
      end
    endcase

    playing_d = (state_d == S_RUN);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      playing_q <= 1'b0;
      offset_q  <= 12'd0;
      speed_q   <= 3'd0;
      taken_q   <= 4'd0;
      score_q   <= 16'd0;
      lap_q     <= 8'd0;
      ramp_q    <= '0;
      fc0_q     <= 1'b0;
      fc1_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      playing_q <= playing_d;
      offset_q  <= offset_d;
      speed_q   <= speed_d;
      taken_q   <= taken_d;
      score_q   <= score_d;
      lap_q     <= lap_d;
      ramp_q    <= ramp_d;
      fc0_q     <= frame_clk;
      fc1_q     <= fc0_q;
    end
  end

  assign playing       = playing_q;
  assign scroll_offset = offset_q;
  assign speed         = speed_q;
  assign coin_taken    = taken_q;
  assign score         = score_q;
  assign lap           = lap_q;
  assign state         = state_q;

endmodule

// File: tb/tb_scroll_ctrl.sv
// Bench for scroll_ctrl: directed scenarios plus randomized play, all checked
// against a game-rules model that tracks score, offset and laps as integers.
module tb_scroll_ctrl;

  localparam int OMAX = 4095;
  localparam int SI   = 2;
  localparam int SMAX = 6;
  localparam int RF   = 4;
  localparam int CP   = 5000;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        dead = 1'b0;
  logic [3:0]  coin_hit = 4'd0;
  logic        playing;
  logic [11:0] scroll_offset;
  logic [2:0]  speed;
  logic [3:0]  coin_taken;
  logic [15:0] score;
  logic [7:0]  lap;
  logic [1:0]  state;

  int errors = 0;
  int checks = 0;

  // Reference model: game state as plain integers (0 IDLE, 1 RUN, 2 PAUSE, 3 OVER).
  int m_st, m_off, m_spd, m_ramp, m_score, m_lap, m_taken;
  bit m_h1, m_h2;

  scroll_ctrl #(
    .OFFSET_MAX (OMAX),
    .SPEED_INIT (SI),
    .SPEED_MAX  (SMAX),
    .RAMP_FRAMES(RF),
    .COIN_POINTS(CP)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .start        (start),
    .pause        (pause),
    .dead         (dead),
    .coin_hit     (coin_hit),
    .playing      (playing),
    .scroll_offset(scroll_offset),
    .speed        (speed),
    .coin_taken   (coin_taken),
    .score        (score),
    .lap          (lap),
    .state        (state)
  );

  always #5 Clk = ~Clk;

  task automatic model_step();
    bit tick;
    int add;
    int nw;
    int total;
    bit wrapped;
    tick = m_h1 && !m_h2;
    m_h2 = m_h1;
    m_h1 = frame_clk;
    if (Reset) begin
      m_st = 0; m_off = 0; m_spd = 0; m_ramp = 0;
      m_score = 0; m_lap = 0; m_taken = 0; m_h1 = 0; m_h2 = 0;
      return;
    end
    case (m_st)
      0: begin
        m_off = 0;
        if (start) begin
          m_st = 1; m_spd = SI; m_score = 0; m_lap = 0; m_taken = 0; m_ramp = 0;
        end
      end
      1: begin
        add = 0;
        wrapped = 0;
        if (tick) begin
          total = m_off + m_spd;
          if (total > OMAX) begin
            m_off = total - (OMAX + 1);
            m_lap = (m_lap + 1) % 256;
            m_taken = 0;
            wrapped = 1;
          end else begin
            m_off = total;
          end
          m_ramp = m_ramp + 1;
          if (m_ramp == RF) begin
            m_ramp = 0;
            if (m_spd < SMAX) m_spd = m_spd + 1;
          end
          add = 1;
        end
        if (!wrapped) begin
          nw = int'(coin_hit) & ~m_taken & 15;
          m_taken = m_taken | nw;
          add = add + CP * $countones(nw);
        end
        m_score = (m_score + add > 65535) ? 65535 : m_score + add;
        if (dead)       m_st = 3;
        else if (pause) m_st = 2;
      end
      2: begin
        if (dead)       m_st = 3;
        else if (pause) m_st = 1;
      end
      default: begin
        if (start) m_st = 0;
      end
    endcase
  endtask

  task automatic step();
    @(posedge Clk);
    model_step();
    #1;
  endtask

  task automatic frame_pulse();
    frame_clk = 1'b1;
    step(); step();
    frame_clk = 1'b0;
    step(); step();
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_pause();
    pause = 1'b1; step(); pause = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; start = 1'b1; frame_clk = 1'b1;
    step(); step();
    start = 1'b0; frame_clk = 1'b0;
    step();
    checks++;
    if ({state, playing, scroll_offset, speed, coin_taken, score, lap} !== 46'd0) begin
      errors++;
      $display("FAIL reset_outputs: got st=%0d pl=%0d off=%0d spd=%0d tk=%0h sc=%0d lap=%0d, want all 0",
               state, playing, scroll_offset, speed, coin_taken, score, lap);
    end
    Reset = 1'b0;
    step();
    checks++;
    if (state !== 2'd0 || playing !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got st=%0d pl=%0d, want st=0 pl=0", state, playing);
    end
    $display("test_reset done");
  endtask

  task automatic test_start_frames();
    pulse_start();
    checks++;
    if (state !== 2'd1 || playing !== 1'b1 || speed !== 3'(SI)) begin
      errors++;
      $display("FAIL start_run: got st=%0d pl=%0d spd=%0d, want st=1 pl=1 spd=%0d", state, playing, speed, SI);
    end
    pulse_start();  // ignored in RUN
    repeat (3) frame_pulse();
    checks++;
    if (state !== 2'd1 || speed !== 3'd2 || scroll_offset !== 12'd6 || score !== 16'd3 || lap !== 8'd0) begin
      errors++;
      $display("FAIL three_frames: got st=%0d spd=%0d off=%0d sc=%0d lap=%0d, want st=1 spd=2 off=6 sc=3 lap=0",
               state, speed, scroll_offset, score, lap);
    end
    $display("test_start_frames done: off=%0d score=%0d", scroll_offset, score);
  endtask

  task automatic test_coins();
    int s0;
    s0 = m_score;
    coin_hit = 4'b0101;
    repeat (3) step();
    coin_hit = 4'b0000;
    step();
    checks++;
    if (coin_taken !== 4'b0101 || int'(score) != s0 + 2 * CP) begin
      errors++;
      $display("FAIL coins_0101: got tk=%b sc=%0d, want tk=0101 sc=%0d", coin_taken, score, s0 + 2 * CP);
    end
    coin_hit = 4'b0111;
    step();
    coin_hit = 4'b0000;
    step();
    checks++;
    if (coin_taken !== 4'b0111 || int'(score) != s0 + 3 * CP) begin
      errors++;
      $display("FAIL coins_0111: got tk=%b sc=%0d, want tk=0111 sc=%0d", coin_taken, score, s0 + 3 * CP);
    end
    $display("test_coins done: taken=%b score=%0d", coin_taken, score);
  endtask

  task automatic test_pause();
    int off0, sc0;
    pulse_pause();
    off0 = m_off;
    sc0  = m_score;
    checks++;
    if (state !== 2'd2 || playing !== 1'b0) begin
      errors++;
      $display("FAIL pause_enter: got st=%0d pl=%0d, want st=2 pl=0", state, playing);
    end
    coin_hit = 4'b1000;
    pulse_start();
    repeat (5) frame_pulse();
    coin_hit = 4'b0000;
    checks++;
    if (int'(scroll_offset) != off0 || int'(score) != sc0 || state !== 2'd2 || coin_taken[3] !== 1'b0) begin
      errors++;
      $display("FAIL pause_frozen: got off=%0d sc=%0d st=%0d tk=%b, want off=%0d sc=%0d st=2 tk[3]=0",
               scroll_offset, score, state, coin_taken, off0, sc0);
    end
    pulse_pause();
    checks++;
    if (state !== 2'd1 || playing !== 1'b1) begin
      errors++;
      $display("FAIL pause_exit: got st=%0d pl=%0d, want st=1 pl=1", state, playing);
    end
    $display("test_pause done");
  endtask

  task automatic test_dead_pause();
    int sc0;
    dead = 1'b1; pause = 1'b1;
    step();
    dead = 1'b0; pause = 1'b0;
    sc0 = m_score;
    repeat (2) frame_pulse();
    checks++;
    if (state !== 2'd3 || playing !== 1'b0 || int'(score) != sc0) begin
      errors++;
      $display("FAIL dead_wins: got st=%0d pl=%0d sc=%0d, want st=3 pl=0 sc=%0d", state, playing, score, sc0);
    end
    pulse_start();
    step();
    checks++;
    if (state !== 2'd0 || scroll_offset !== 12'd0 || int'(score) != sc0) begin
      errors++;
      $display("FAIL over_to_idle: got st=%0d off=%0d sc=%0d, want st=0 off=0 sc=%0d", state, scroll_offset, score, sc0);
    end
    pulse_start();
    checks++;
    if (state !== 2'd1 || score !== 16'd0 || lap !== 8'd0 || coin_taken !== 4'd0 || speed !== 3'(SI)) begin
      errors++;
      $display("FAIL restart: got st=%0d sc=%0d lap=%0d tk=%b spd=%0d, want st=1 sc=0 lap=0 tk=0 spd=%0d",
               state, score, lap, coin_taken, speed, SI);
    end
    $display("test_dead_pause done");
  endtask

  // Fresh game: speed and distance follow closed-form expressions of the frame count.
  task automatic test_ramp_wrap();
    int total, exp_spd, exp_off, exp_lap, k;
    bit wrapped_seen;
    total = 0;
    wrapped_seen = 0;
    coin_hit = 4'b0011;
    step();
    coin_hit = 4'b0000;
    for (k = 1; k <= 1000 && !wrapped_seen; k++) begin
      total   = total + ((SI + (k - 1) / RF < SMAX) ? SI + (k - 1) / RF : SMAX);
      exp_spd = (SI + k / RF < SMAX) ? SI + k / RF : SMAX;
      exp_off = total % (OMAX + 1);
      exp_lap = total / (OMAX + 1);
      frame_pulse();
      checks++;
      if (int'(speed) != exp_spd || int'(scroll_offset) != exp_off || int'(lap) != exp_lap) begin
        errors++;
        $display("FAIL ramp_frame%0d: got spd=%0d off=%0d lap=%0d, want spd=%0d off=%0d lap=%0d",
                 k, speed, scroll_offset, lap, exp_spd, exp_off, exp_lap);
      end
      if (exp_lap == 1) begin
        wrapped_seen = 1;
        checks++;
        if (coin_taken !== 4'd0) begin
          errors++;
          $display("FAIL wrap_clear: got tk=%b, want 0000", coin_taken);
        end
      end
    end
    checks++;
    if (!wrapped_seen) begin
      errors++;
      $display("FAIL wrap_reached: got no wrap within 1000 frames, want one");
    end
    $display("test_ramp_wrap done: frames=%0d off=%0d lap=%0d", k - 1, scroll_offset, lap);
  endtask

  task automatic test_saturation();
    int n;
    coin_hit = 4'b1111;
    for (n = 0; n < 3000 && m_score < 65535; n++) frame_pulse();
    repeat (5) frame_pulse();
    coin_hit = 4'b0000;
    checks++;
    if (score !== 16'hFFFF || int'(score) != m_score) begin
      errors++;
      $display("FAIL score_saturate: got sc=%0d, want 65535 (model %0d)", score, m_score);
    end
    checks++;
    if (int'(scroll_offset) != m_off || int'(lap) != m_lap || int'(coin_taken) != m_taken) begin
      errors++;
      $display("FAIL sat_state: got off=%0d lap=%0d tk=%b, want off=%0d lap=%0d tk=%0h",
               scroll_offset, lap, coin_taken, m_off, m_lap, m_taken);
    end
    $display("test_saturation done: score=%0d lap=%0d", score, lap);
  endtask

  task automatic test_reset_midgame();
    frame_clk = 1'b1;
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    frame_clk = 1'b0;
    step();
    checks++;
    if ({state, playing, scroll_offset, speed, coin_taken, score, lap} !== 46'd0) begin
      errors++;
      $display("FAIL reset_midgame: got st=%0d off=%0d spd=%0d tk=%b sc=%0d lap=%0d, want all 0",
               state, scroll_offset, speed, coin_taken, score, lap);
    end
    $display("test_reset_midgame done");
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0) frame_clk = ~frame_clk;
      start    = ($urandom_range(0, 24) == 0);
      pause    = ($urandom_range(0, 39) == 0);
      dead     = ($urandom_range(0, 149) == 0);
      coin_hit = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0;
      Reset    = ($urandom_range(0, 999) == 0);
      step();
      checks++;
      if (int'(state) != m_st || playing !== (m_st == 1) || int'(scroll_offset) != m_off ||
          int'(speed) != m_spd || int'(coin_taken) != m_taken || int'(score) != m_score ||
          int'(lap) != m_lap) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_cycle%0d: got st=%0d pl=%0d off=%0d spd=%0d tk=%b sc=%0d lap=%0d, want st=%0d off=%0d spd=%0d tk=%0h sc=%0d lap=%0d",
                   i, state, playing, scroll_offset, speed, coin_taken, score, lap,
                   m_st, m_off, m_spd, m_taken, m_score, m_lap);
      end
    end
    start = 0; pause = 0; dead = 0; coin_hit = 0; Reset = 0;
    $display("test_random done: 4000 cycles");
  endtask

  initial begin
    m_st = 0; m_off = 0; m_spd = 0; m_ramp = 0;
    m_score = 0; m_lap = 0; m_taken = 0; m_h1 = 0; m_h2 = 0;
    test_reset();
    test_start_frames();
    test_coins();
    test_pause();
    test_dead_pause();
    test_ramp_wrap();
    test_saturation();
    test_reset_midgame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
